// File: rtl/sync_nff_filt.sv
// sync_nff_filt: per-channel N-flop synchronizer with optional stability filter (SYNC_NFF_FILT_FILTER_EN) and edge pulses
module sync_nff_filt #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] FF_INIT = {WIDTH{1'b0}},
  parameter int FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  if (WIDTH < 1 || WIDTH > 32 || STAGES < 2 || STAGES > 4 || FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_param
    $error("sync_nff_filt: parameter out of range");
  end
  logic [STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] tog;
  assign s = sync[STAGES-1];
  // synchronizer chain shifts every cycle, independent of en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= {STAGES{FF_INIT}};
    else sync <= {sync[STAGES-2:0], din};
  end
`ifdef SYNC_NFF_FILT_FILTER_EN
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [WIDTH-1:0][CW-1:0] cnt, cnt_nxt;
  // a channel toggles only after s has disagreed with dout for FILT_CYCLES consecutive enabled cycles
  always_comb begin
    tog = '0;
    cnt_nxt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      tog[k] = en && (s[k] != dout[k]) && (cnt[k] == CW'(FILT_CYCLES - 1));
      cnt_nxt[k] = (en && (s[k] != dout[k]) && !tog[k]) ? cnt[k] + CW'(1) : '0;
    end
  end
  // stability counters, cleared on agreement, acceptance or en low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else cnt <= cnt_nxt;
  end
`else
  // unfiltered: dout follows s whenever enabled
  always_comb tog = en ? (s ^ dout) : '0;
`endif
  // registered level and edge pulses; pulses derive from the accepted toggle, so reset never pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= FF_INIT;
      rise <= '0;
      fall <= '0;
      changed <= 1'b0;
    end else begin
      dout <= dout ^ tog;
      rise <= tog & ~dout;
      fall <= tog & dout;
      changed <= |tog;
    end
  end
endmodule

// File: tb/tb_sync_nff_filt.sv
// tb_sync_nff_filt: scoreboard bench for sync_nff_filt (8-channel filtered instance plus 1-channel FF_INIT=1 instance)
module tb_sync_nff_filt;
  localparam int SA = 3;
  localparam int FA = 4;
  localparam int SB = 2;
  localparam int FB = 4;
`ifdef SYNC_NFF_FILT_FILTER_EN
  localparam int LAT_A = SA + FA;
  localparam int LAT_B = SB + FB;
`else
  localparam int LAT_A = SA + 1;
  localparam int LAT_B = SB + 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [7:0] din_a = '0;
  logic [7:0] dout_a, rise_a, fall_a;
  logic changed_a;
  logic din_b = 1'b1;
  logic dout_b, rise_b, fall_b, changed_b;
  int n_chk = 0;
  int n_fail = 0;
  logic [24:0] exp_q[$];
  logic [7:0] m_sync[SA];
  logic [7:0] m_dout, m_rise, m_fall;
  logic m_chg;
  int m_cnt[8];
  always #5 clk = ~clk;
  sync_nff_filt #(.WIDTH(8), .STAGES(SA), .FF_INIT(8'h00), .FILT_CYCLES(FA)) u_a (
    .clk(clk), .rst(rst), .en(en), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );
  sync_nff_filt #(.WIDTH(1), .STAGES(SB), .FF_INIT(1'b1), .FILT_CYCLES(FB)) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < SA; k++) m_sync[k] = 8'h00;
    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    m_dout = 8'h00;
    m_rise = 8'h00;
    m_fall = 8'h00;
    m_chg = 1'b0;
  endtask
  task automatic model_edge();
    logic [7:0] s, t;
    if (!rst) begin
      model_reset();
      return;
    end
    s = m_sync[SA-1];
    t = 8'h00;
    for (int k = 0; k < 8; k++) begin
`ifdef SYNC_NFF_FILT_FILTER_EN
      if (!en || s[k] == m_dout[k]) m_cnt[k] = 0;
      else if (m_cnt[k] + 1 >= FA) begin
        t[k] = 1'b1;
        m_cnt[k] = 0;
      end else m_cnt[k]++;
`else
      t[k] = en && (s[k] != m_dout[k]);
`endif
    end
    m_rise = t & ~m_dout;
    m_fall = t & m_dout;
    m_chg = |t;
    m_dout = m_dout ^ t;
    for (int k = SA - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = din_a;
  endtask
  task automatic cyc(input logic [7:0] d, input logic e);
    logic [24:0] want;
    din_a = d;
    en = e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_dout, m_rise, m_fall, m_chg});
    @(negedge clk);
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      want = exp_q.pop_front();
      chk("sb_a", {7'd0, dout_a, rise_a, fall_a, changed_a}, {7'd0, want});
    end
  endtask
  initial begin
    logic [7:0] sticky;
    logic [7:0] d;
    logic pb;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_dout_a", dout_a, 8'h00);
    chk("rst_pulses_a", {rise_a, fall_a, 7'd0, changed_a}, 0);
    chk("rst_dout_b_async", dout_b, 1);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    rst = 1'b1;
    pb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(8'h00, 1'b1);
      pb |= rise_b | fall_b | changed_b;
    end
    chk("b_release_nopulse", pb, 0);
    chk("b_release_dout", dout_b, 1);
    for (int i = 0; i < LAT_A - 1; i++) cyc(8'hA5, 1'b1);
    chk("a5_before_lat", dout_a, 8'h00);
    cyc(8'hA5, 1'b1);
    chk("a5_dout", dout_a, 8'hA5);
    chk("a5_rise", rise_a, 8'hA5);
    chk("a5_fall", fall_a, 8'h00);
    chk("a5_changed", changed_a, 1);
    cyc(8'hA5, 1'b1);
    chk("a5_rise_once", rise_a, 8'h00);
    chk("a5_changed_once", changed_a, 0);
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b1);
    chk("a_back_zero", dout_a, 8'h00);
    sticky = 8'h00;
    for (int i = 0; i < 3; i++) cyc(8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 1'b1);
      sticky |= dout_a | rise_a | fall_a | {7'd0, changed_a};
    end
`ifdef SYNC_NFF_FILT_FILTER_EN
    chk("glitch_ignored", sticky, 8'h00);
    for (int i = 0; i < SA + 2; i++) cyc(8'h01, 1'b1);
    cyc(8'h01, 1'b0);
    chk("en_drop_hold", dout_a, 8'h00);
    chk("en_drop_nopulse", rise_a, 8'h00);
    for (int i = 0; i < FA - 1; i++) cyc(8'h01, 1'b1);
    chk("en_restore_wait", dout_a, 8'h00);
    cyc(8'h01, 1'b1);
    chk("en_restore_accept", dout_a, 8'h01);
    chk("en_restore_rise", rise_a, 8'h01);
`else
    chk("glitch_passes", sticky, 8'hFF);
    for (int i = 0; i < 8; i++) cyc(8'h3C, 1'b0);
    chk("en_low_hold", dout_a, 8'h00);
    cyc(8'h3C, 1'b1);
    chk("en_high_load", dout_a, 8'h3C);
    chk("en_high_rise", rise_a, 8'h3C);
`endif
    d = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) d = d ^ 8'($urandom_range(0, 255));
      cyc(d, $urandom_range(0, 9) != 0);
    end
    din_b = 1'b0;
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b1);
    chk("b_low", dout_b, 0);
    din_b = 1'b1;
    for (int i = 0; i < LAT_B - 1; i++) cyc(8'h00, 1'b1);
    chk("b_before_lat", dout_b, 0);
    cyc(8'h00, 1'b1);
    chk("b_rise", {dout_b, rise_b, fall_b}, 3'b110);
    cyc(8'h00, 1'b1);
    chk("b_rise_once", rise_b, 0);
    din_b = 1'b0;
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b1);
    chk("b_low_again", dout_b, 0);
    din_b = 1'b1;
    cyc(8'hFF, 1'b1);
    cyc(8'hFF, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_dout_a", dout_a, 8'h00);
    chk("mid_rst_pulses_a", {rise_a, fall_a, 7'd0, changed_a}, 0);
    chk("mid_rst_dout_b", dout_b, 1);
    cyc(8'hFF, 1'b1);
    cyc(8'h00, 1'b1);
    rst = 1'b1;
    pb = 1'b0;
    sticky = 8'h00;
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 1'b1);
      pb |= rise_b | fall_b | changed_b;
      sticky |= dout_a | rise_a | fall_a;
    end
    chk("b_rel_nopulse", pb, 0);
    chk("b_rel_dout", dout_b, 1);
    chk("a_aborted", sticky, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_nff_filt.md
SYNC_NFF_FILT -- requirements
Module: sync_nff_filt

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning the number of independent channels (legal 1..32).
REQ-002 SHALL have parameter STAGES, default 2, meaning the synchronizer flip-flop depth per channel (legal 2..4).
REQ-003 SHALL have parameter FF_INIT, default {WIDTH{1'b0}}, meaning the reset value of every synchronizer flop and of dout.
REQ-004 SHALL have parameter FILT_CYCLES, default 4, meaning the number of consecutive stable cycles needed to accept a change (legal 1..255).
REQ-005 SHALL have port clk, input, 1 bit: the destination domain clock.
REQ-006 SHALL have port rst, input, 1 bit: the destination domain reset, asynchronous and active-low.
REQ-007 SHALL have port en, input, 1 bit: update enable, synchronous to clk.
REQ-008 SHALL have port din, input, WIDTH bits: asynchronous source-domain data, one bit per channel.
REQ-009 SHALL have port dout, output, WIDTH bits: synchronized (and filtered) level.
REQ-010 SHALL have port rise, output, WIDTH bits: one-cycle pulse per channel on a 0->1 change of dout.
REQ-011 SHALL have port fall, output, WIDTH bits: one-cycle pulse per channel on a 1->0 change of dout.
REQ-012 SHALL have port changed, output, 1 bit: the OR of (rise | fall).

Function
REQ-013 Each channel SHALL pass din[i] through a chain of STAGES flops clocked by clk; the last flop output is s[i].
REQ-014 The synchronizer chain SHALL shift every cycle regardless of en.
REQ-015 dout, rise, fall and changed SHALL all be registered outputs, with no combinational path from din.
REQ-016 rise[i] SHALL be 1 in exactly the first cycle where dout[i]=1 following dout[i]=0; fall[i] SHALL be the mirror case; neither SHALL exceed one cycle.
REQ-017 When en=0, dout SHALL hold, rise/fall/changed SHALL be 0, and the filter counters SHALL clear to 0.
REQ-018 With filtering disabled (see Configuration), when en=1 then dout[i] SHALL load s[i] each cycle, giving a din-to-dout latency of STAGES+1 clk edges.
REQ-019 With filtering enabled, each channel SHALL keep a counter cnt[i] of width clog2(FILT_CYCLES+1), run as follows.
REQ-020 Filter rule, s[i]==dout[i]: cnt[i] SHALL be set to 0.
REQ-021 Filter rule, s[i]!=dout[i] and cnt[i]<FILT_CYCLES-1: cnt[i] SHALL increment.
REQ-022 Filter rule, s[i]!=dout[i] and cnt[i]==FILT_CYCLES-1: dout[i] SHALL toggle on the next edge, the matching rise/fall SHALL pulse, and cnt[i] SHALL be set to 0.
REQ-023 A glitch on s[i] shorter than FILT_CYCLES cycles SHALL cause no change on dout[i] and no pulse; a level held FILT_CYCLES cycles SHALL be accepted, for a latency of STAGES+FILT_CYCLES edges.
REQ-024 FILT_CYCLES=1 SHALL behave identically to filtering disabled.
REQ-025 cnt[i] SHALL never exceed FILT_CYCLES-1 and SHALL never wrap.
REQ-026 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulse in the same cycle, with changed=1 for that one cycle.
REQ-027 If en falls in the same cycle a change would be accepted, en SHALL win: no toggle, no pulse, cnt cleared.

Reset
REQ-028 While rst=0, all synchronizer flops and dout SHALL be FF_INIT, and rise, fall, changed and every cnt SHALL be 0, asynchronously and independent of clk.
REQ-029 Assertion of rst mid-filter SHALL abort any pending change with no pulse.
REQ-030 The first edge after rst deasserts SHALL NOT generate a pulse for the reset value itself; pulses SHALL arise only from later dout changes.

Configuration
REQ-031 Macro SYNC_NFF_FILT_FILTER_EN defined: the filter counters of REQ-019..REQ-025 SHALL be compiled in.
REQ-032 Macro SYNC_NFF_FILT_FILTER_EN undefined: no counters SHALL exist, FILT_CYCLES SHALL be ignored, and REQ-018 behaviour SHALL apply.

Verification
REQ-033 Unfiltered, WIDTH=1, STAGES=2, en=1, din 0->1 at edge N -> dout=1 and rise=1 at edge N+3, rise=0 at N+4.
REQ-034 Filtered, FILT_CYCLES=4, STAGES=3, a 3-cycle-wide high glitch on din -> dout stays 0 and rise/fall/changed stay 0 throughout.
REQ-035 Filtered, FILT_CYCLES=4, STAGES=3, din held high -> dout=1 and rise=1 exactly 7 edges after the din change; then din low -> fall=1 after 7 edges.
REQ-036 WIDTH=8, din 8'h00->8'hA5 in one cycle -> rise=8'hA5 for one cycle, changed=1 for one cycle, fall=8'h00.
REQ-037 Filtered, en dropped at cnt=2 mid-change -> no toggle and cnt=0; en restored with din still high -> acceptance after a further full FILT_CYCLES.
REQ-038 FF_INIT=1, rst asserted mid-operation then released with din=1 -> dout=1 asynchronously during reset, and no rise or fall pulse after release.
